// File: rtl/adder_operand_loader.sv
// Operand loader for the 5-bit ripple adder: button-stepped capture of A, B/cin, one-cycle
// adder sample and registered result. Define DEBOUNCE_EN to insert a debounce counter on the button.
module adder_operand_loader #(
   parameter int WIDTH     = 5,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_data,
   input  logic             sw_cin,
   input  logic             load_btn,
   input  logic             clr,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_cin,
   output logic             op_valid,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic [WIDTH:0]   result,
   output logic             res_valid,
   output logic [1:0]       stage
);

   localparam logic [1:0] S_A    = 2'd0;
   localparam logic [1:0] S_B    = 2'd1;
   localparam logic [1:0] S_ADD  = 2'd2;
   localparam logic [1:0] S_SHOW = 2'd3;

   logic       sync1;
   logic       sync2;
   logic       level;
   logic       level_prev;
   logic       press;
   logic [1:0] state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= load_btn;
         sync2 <= sync1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [CW-1:0] db_count;
   logic          db_level;

   // The level follows the synchronized input only after DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_count <= '0;
         db_level <= 1'b0;
      end else if (sync2 != db_level) begin
         if (db_count == CW'(DB_CYCLES - 1)) begin
            db_level <= sync2;
            db_count <= '0;
         end else begin
            db_count <= db_count + CW'(1);
         end
      end else begin
         db_count <= '0;
      end
   end

   assign level = db_level;
`else
   assign level = sync2;
`endif

   // Registered edge detect so the press pulse is a clean single-cycle flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev <= 1'b0;
         press      <= 1'b0;
      end else begin
         level_prev <= level;
         press      <= level & ~level_prev;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_A;
         op_a      <= '0;
         op_b      <= '0;
         op_cin    <= 1'b0;
         result    <= '0;
         res_valid <= 1'b0;
      end else if (clr) begin
         state     <= S_A;
         op_a      <= '0;
         op_b      <= '0;
         op_cin    <= 1'b0;
         result    <= '0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (press) begin
                  op_a  <= sw_data;
                  state <= S_B;
               end
            end
            S_B: begin
               if (press) begin
                  op_b   <= sw_data;
                  op_cin <= sw_cin;
                  state  <= S_ADD;
               end
            end
            S_ADD: begin
               // Presses landing here are intentionally dropped.
               result    <= {add_cout, add_sum};
               res_valid <= 1'b1;
               state     <= S_SHOW;
            end
            default: begin
               if (press) begin
                  res_valid <= 1'b0;
                  state     <= S_A;
               end
            end
         endcase
      end
   end

   assign op_valid = (state == S_ADD);
   assign stage    = state;

endmodule

// File: doc/adder_operand_loader.md
Name: adder_operand_loader

Overview:
- Sequential front end for the 5-bit ripple adder.
- Captures operand A, operand B and carry-in from slide switches using successive presses of a load button.
- Presents the captured operands to the adder for one evaluation cycle, then registers the adder's 6-bit result {carry_out, sum} for display.
- Sits between board I/O (switches/buttons) and the adder's a/b/carry_in inputs; also consumes the adder's sum/carry_out.

Parameters:
- WIDTH, 5, operand width; the adder is 5 bits.
- DB_CYCLES, 16, debounce stable-count in clocks; used only when DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- sw_data  in  WIDTH  operand value from switches.
- sw_cin  in  1  carry-in value from a switch.
- load_btn  in  1  raw load button; asynchronous to clk.
- clr  in  1  synchronous clear; already synchronous to clk.
- op_a  out  WIDTH  operand A to the adder.
- op_b  out  WIDTH  operand B to the adder.
- op_cin  out  1  carry-in to the adder.
- op_valid  out  1  one-cycle strobe: operands stable, adder being sampled.
- add_sum  in  WIDTH  adder sum, combinational from op_a/op_b/op_cin.
- add_cout  in  1  adder carry_out.
- result  out  WIDTH+1  registered {add_cout, add_sum}.
- res_valid  out  1  result holds a fresh value.
- stage  out  2  current FSM state, for LEDs.

Behaviour:
- Reset (rst_n=0, asynchronous), all outputs go to 0:
  - op_a=0, op_b=0, op_cin=0, op_valid=0, result=0, res_valid=0, stage=0.
  - FSM goes to S_A.
  - Synchronizer and edge-detect flops go to 0.
  - Deassertion of rst_n takes effect at the next clk edge.
  - Reset mid-sequence discards all captured operands.
- Button path:
  - load_btn passes through a 2-flop synchronizer, then a rising-edge detector.
  - The detector produces a 1-cycle press pulse.
  - Latency from button to pulse is 3 clocks.
  - Holding the button produces exactly one pulse.
- FSM states (stage encoding): S_A=0, S_B=1, S_ADD=2, S_SHOW=3.
  - S_A: on press, op_a <= sw_data, go to S_B.
  - S_B: on press, op_b <= sw_data and op_cin <= sw_cin, go to S_ADD.
  - S_ADD: lasts exactly 1 cycle.
    - op_valid=1 for this cycle.
    - At the closing edge, result <= {add_cout, add_sum} and res_valid <= 1.
    - Go to S_SHOW unconditionally.
    - A press arriving during S_ADD is ignored and not queued.
  - S_SHOW: result and res_valid are held.
    - On press, res_valid <= 0 and go to S_A.
    - op_a/op_b/op_cin keep their old values until overwritten.
- op_valid is asserted only in S_ADD; it is never asserted two cycles in a row.
- Arithmetic is done entirely in the external adder; this block adds nothing.
  - result[WIDTH] is the carry/overflow bit.
  - Maximum result is 31+31+1 = 63 = 6'b111111.
- clr:
  - From any state, go to S_A on the next edge.
  - op_a=op_b=op_cin=0, result=0, res_valid=0.
  - clr and press in the same cycle: clr wins and the press is dropped.
- Switch values are sampled only on the press-pulse cycle; switch changes at any other time have no effect.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - A counter follows the synchronizer.
  - The debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive clocks.
  - The edge detector runs on the debounced level.
  - Press latency is 2 + DB_CYCLES + 1 clocks.
  - Glitches shorter than DB_CYCLES produce no pulse.
  - The counter resets to 0.
- Undefined:
  - No debounce logic.
  - The edge detector runs directly on the synchronizer output; latency is 3 clocks.
  - DB_CYCLES is unused.

Test Plan:
- Reset then idle → all outputs 0, stage=0, op_valid never asserted over 50 cycles.
- Three presses with A=5'd13, B=5'd9, cin=1; adder model in bench:
  - op_valid pulses once, with op_a=13, op_b=9, op_cin=1.
  - The next cycle shows result=6'd23, res_valid=1, stage=3.
- Sequence A=31, B=31, cin=1 → result=6'b111111 (63).
  - A fourth press clears res_valid and gives stage=0, with op_a still 31.
- Load button held 100 cycles in S_A → exactly one capture; stage goes 0→1 only.
- clr asserted in S_B in the same cycle as a press → stage=0, op_a=0, op_b unchanged at 0, no op_valid.
- rst_n pulsed low asynchronously during S_SHOW with result=23 → result=0 and res_valid=0 immediately, without waiting for clk.
  - With DEBOUNCE_EN and DB_CYCLES=16, a 10-cycle glitch gives no capture; a 20-cycle press gives one capture.
